// File: rtl/lane_queue_tracker_pkg.sv
// lane_queue_tracker_pkg: shared lane indices, emergency FSM encoding and default tuning values
package lane_queue_tracker_pkg;
  localparam int N1 = 7;
  localparam int N2 = 6;
  localparam int E1 = 5;
  localparam int E2 = 4;
  localparam int S1 = 3;
  localparam int S2 = 2;
  localparam int W1 = 1;
  localparam int W2 = 0;
  localparam int LANES_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int DRAIN_DIV_DEF = 4;
  localparam int EMG_TIMEOUT_DEF = 64;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVE   = 2'd2,
    ST_RELEASE = 2'd3
  } emg_state_t;
endpackage

// File: rtl/lane_queue_tracker_lane_counter.sv
// lane_counter: per-lane saturating vehicle count with green-time drain divider
module lane_counter
  import lane_queue_tracker_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DRAIN_DIV = DRAIN_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arrive,
  input  logic             green,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             isEmpty
);
  localparam int DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [DW-1:0] div, div_next;
  logic [CNT_W-1:0] count_next;
  logic wrap, dep, ovf_next;
  // divider runs only on green; a departure needs a full wrap and a non-empty queue
  always_comb begin
    wrap = green && (div == DW'(DRAIN_DIV - 1));
    dep = wrap && (count != '0);
    div_next = (!green || wrap) ? '0 : div + DW'(1);
    count_next = (arrive && !dep) ? ((count == MAX) ? MAX : count + CNT_W'(1)) :
                 (dep && !arrive) ? count - CNT_W'(1) : count;
    ovf_next = ovf || (arrive && !dep && count == MAX);
  end
  // count, divider and sticky overflow registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      div <= div_next;
      count <= count_next;
      ovf <= ovf_next;
    end
  end
  assign isEmpty = (count == '0);
endmodule

// File: rtl/lane_queue_tracker.sv
// lane_queue_tracker: packs per-lane queue counts and drives the emergency request to the controller
module lane_queue_tracker
  import lane_queue_tracker_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DRAIN_DIV = DRAIN_DIV_DEF,
  parameter int EMG_TIMEOUT = EMG_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       arrive,
  input  logic [LANES-1:0]       lightIn,
  input  logic                   emgReq,
  input  logic [2:0]             emgLaneIn,
  output logic [LANES*CNT_W-1:0] lanes,
  output logic                   emgSignal,
  output logic [LANES-1:0]       emgLane,
  output logic [LANES-1:0]       ovf,
  output logic                   emgDropped
);
  localparam int TW = $clog2(EMG_TIMEOUT);
  logic [LANES-1:0] empty;
  emg_state_t state, state_next;
  logic [2:0] lat, lat_next;
  logic [TW-1:0] timer, timer_next;
  logic timeout, hold_next;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_counter #(.CNT_W(CNT_W), .DRAIN_DIV(DRAIN_DIV)) u_cnt (
      .clk(clk),
      .rst(rst),
      .arrive(arrive[g]),
      .green(lightIn[g]),
      .count(lanes[g*CNT_W +: CNT_W]),
      .ovf(ovf[g]),
      .isEmpty(empty[g])
    );
  end
  // emergency next state: hold until served lane drains, or the hold timer expires
  always_comb begin
    state_next = state;
    lat_next = lat;
    timer_next = timer;
    timeout = (timer == TW'(EMG_TIMEOUT - 1));
    case (state)
      ST_IDLE: if (emgReq) begin
        state_next = ST_ASSERT;
        lat_next = emgLaneIn;
        timer_next = '0;
      end
      ST_ASSERT: begin
        timer_next = timer + TW'(1);
        state_next = timeout ? ST_RELEASE : lightIn[lat] ? ST_SERVE : ST_ASSERT;
      end
      ST_SERVE: begin
        timer_next = timer + TW'(1);
        state_next = (timeout || empty[lat]) ? ST_RELEASE : ST_SERVE;
      end
      default: state_next = ST_IDLE;
    endcase
    hold_next = (state_next == ST_ASSERT) || (state_next == ST_SERVE);
  end
  // FSM state plus registered request outputs derived from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      lat <= '0;
      timer <= '0;
      emgSignal <= 1'b0;
      emgLane <= '0;
      emgDropped <= 1'b0;
    end else begin
      state <= state_next;
      lat <= lat_next;
      timer <= timer_next;
      emgSignal <= hold_next;
      emgLane <= hold_next ? LANES'(1) << lat_next : '0;
      emgDropped <= emgReq && (state != ST_IDLE);
    end
  end
endmodule

// File: doc/lane_queue_tracker.md
Name: lane_queue_tracker

Overview:
- Sensor-side producer of the packed lane-count bus and the emergency request pair consumed by the traffic controller.
- Keeps a registered per-lane vehicle queue count from arrival pulses and car-light feedback: the count increments on arrival and drains while the lane is green.
- Raises emgSignal / emgLane for a detected emergency vehicle and holds the request until that lane is served, drained or timed out.
- Sits between the road-sensor stimulus and Breadboard, closing the loop on the controller's car-light output.

Parameters:
- LANES, 8: number of lanes; the bus order is fixed as {n1,n2,e1,e2,s1,s2,w1,w2}, so index 7 = n1 and index 0 = w2.
- CNT_W, 8: width of each lane count; counts saturate at 2^CNT_W-1.
- DRAIN_DIV, 4: number of consecutive green cycles per departing vehicle.
- EMG_TIMEOUT, 64: maximum number of cycles an emergency request is held (ASSERT+SERVE).

Ports:
- clk  in  1: system clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-low reset (asserts immediately on rst=0, releases synchronously to clk).
- arrive  in  LANES: per-lane arrival pulse; 1 = one vehicle joins that lane this cycle.
- lightIn  in  LANES: controller car-light output, bit-aligned with lanes; 1 = green.
- emgReq  in  1: emergency vehicle detected (single-cycle pulse).
- emgLaneIn  in  3: lane index of the emergency vehicle; sampled with emgReq.
- lanes  out  LANES*CNT_W: packed counts; lane i occupies bits [i*CNT_W +: CNT_W].
- emgSignal  out  1: emergency request to the controller.
- emgLane  out  LANES: one-hot emergency lane; all zero when emgSignal=0.
- ovf  out  LANES: sticky per-lane saturation flag.
- emgDropped  out  1: one-cycle pulse when emgReq arrives while not IDLE.

Behaviour:
- Reset values: lanes=0, all drain dividers=0, ovf=0, emgSignal=0, emgLane=0, emgDropped=0, FSM=IDLE, timeout counter=0. All outputs are registered.
- Count latency: an arrive/departure at edge k is visible on lanes after edge k.
- Drain divider (per lane):
  - Increments each cycle while lightIn[i]=1.
  - Clears on the cycle lightIn[i]=0.
  - On reaching DRAIN_DIV-1 it wraps to 0 and produces dep[i]=1 when count[i]>0.
  - At count[i]=0 it keeps running, but dep[i] is suppressed.
- Count update per lane:
  - arrive & dep: unchanged.
  - arrive only: +1; if already at max, hold max and set ovf[i].
  - dep only: -1.
  - The count never underflows.
- ovf clears only on reset.
- Emergency FSM, states IDLE, ASSERT, SERVE, RELEASE:
  - IDLE: on emgReq, latch L=emgLaneIn and clear the timer, then go to ASSERT. emgSignal=1 and emgLane=1<<L are visible the next cycle.
  - ASSERT: the timer counts. Go to SERVE when lightIn[L]=1. Go to RELEASE when the timer reaches EMG_TIMEOUT-1.
  - SERVE: the timer continues. Go to RELEASE when count[L]==0 (checked on the registered value) or the timer reaches EMG_TIMEOUT-1.
  - RELEASE: emgSignal=0 and emgLane=0 for exactly one cycle, then IDLE. A new emgReq is accepted no earlier than the cycle after RELEASE.
  - emgReq in ASSERT, SERVE or RELEASE is ignored and pulses emgDropped for one cycle.
  - Entering ASSERT with count[L] already 0 is not skipped; SERVE exits on its first cycle.
- Reset mid-operation forces all reset values immediately; a pending emergency is lost.
- Counts continue to update in every FSM state; emergency handling does not freeze arrivals.

Decomposition:
- Shared package: lane index constants (N1=7, N2=6, E1=5, E2=4, S1=3, S2=2, W1=1, W2=0), FSM state encoding (2 bits), and default DRAIN_DIV / EMG_TIMEOUT.
- Sub-module lane_counter, one instance per lane. Ports: clk, rst, arrive, green, count, ovf, isEmpty. It contains the drain divider and the saturating counter.
- The top level holds the emergency FSM and the bus packing.

Test Plan:
- Reset: hold rst=0 mid-traffic → lanes=0, ovf=0, emgSignal=0, emgLane=8'b0 immediately, without waiting for a clock edge.
- Arrive/drain: 3 arrive pulses on lane 7, then lightIn[7]=1 for 12 cycles → n1 reads 3, then 2, 1, 0 at green cycles 4, 8, 12, and stays 0 after.
- Simultaneous and saturation: arrive and departure on lane 3 in the same cycle → count unchanged. 256 arrivals on lane 0 → w2=255 and ovf[0]=1 after the 256th.
- Green toggle: lightIn[5] green for 3 cycles, red for 1, green for 3 with count 5 → no departure, because the divider clears on red.
- Emergency served: emgReq with emgLaneIn=3 and s1=2 → emgSignal=1, emgLane=8'b00001000. After lightIn[3]=1 for 8 cycles, s1=0 → one RELEASE cycle, then emgSignal=0 and emgLane=0.
- Timeout and drop: emgReq on lane 1 with lightIn held at 0 → emgSignal deasserts after 64 cycles. A second emgReq at cycle 10 pulses emgDropped=1 for one cycle.
